// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared widths, FSM encodings and bit-order helper for the serial link
package link_pkg;

  localparam int LINK_WORD_W = 16;
  localparam int LINK_CNT_W  = 4;

  // Words are indexed [0:15]; index 0 is the first bit on the wire.
  typedef logic [0:LINK_WORD_W-1] link_word_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Bit order shared with the receiver: word index 0 travels first and is
  // reassembled into DATA_OUT[0] on the far side.
  localparam bit LINK_INDEX0_FIRST = 1'b1;

  // Bit of a word that goes on the wire during serial slot cnt.
  function automatic logic link_bit(input link_word_t w, input logic [LINK_CNT_W-1:0] cnt);
    if (LINK_INDEX0_FIRST) begin
      return w[cnt];
    end else begin
      return w[~cnt];
    end
  endfunction

endpackage

// File: rtl/link_tx_fifo.sv
// rtl/link_tx_fifo.sv - synchronous FIFO buffering words ahead of the serialiser
module link_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // Pointers, level and registered full/empty flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Storage; stale entries are harmless because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/link_transmitter.sv
// rtl/link_transmitter.sv - buffered 16-bit serialiser driving S_OUT/SYNC to the link receiver
module link_transmitter
  import link_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_GAP   = 0
) (
  input  logic                        LINK_CLK,
  input  logic                        RESET,
  input  link_word_t                  DATA_IN,
  input  logic                        DATA_VALID,
  output logic                        DATA_READY,
  output logic                        S_OUT,
  output logic                        SYNC,
  output logic                        BUSY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam int GAP_LOAD = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

  link_word_t             fifo_data;
  logic [LVL_W-1:0]       fifo_level;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   take_next;

  logic [1:0]             state_q, state_d;
  logic [LINK_CNT_W-1:0]  cnt_q, cnt_d;
  link_word_t             word_q, word_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   s_out_q, s_out_d;
  logic                   sync_q, sync_d;
  logic                   busy_q, busy_d;

  link_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LINK_WORD_W)
  ) u_fifo (
    .clk_i   (LINK_CLK),
    .rst_i   (RESET),
    .push_i  (DATA_VALID),
    .data_i  (DATA_IN),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Shifter FSM: walk the held word bit by bit, optionally idle, then reload from the FIFO.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    gap_d     = gap_q;
    s_out_d   = 1'b0;
    sync_d    = 1'b0;
    busy_d    = 1'b0;
    pop       = 1'b0;
    take_next = 1'b0;

    case (state_q)
      ST_SHIFT: begin
        if (cnt_q != LINK_CNT_W'(LINK_WORD_W - 1)) begin
          cnt_d   = cnt_q + 1'b1;
          s_out_d = link_bit(word_q, cnt_d);
          sync_d  = (cnt_d == LINK_CNT_W'(LINK_WORD_W - 1));
          busy_d  = 1'b1;
        end else if (IDLE_GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP_LOAD);
          busy_d  = 1'b1;
        end else begin
          take_next = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d  = gap_q - 1'b1;
          busy_d = 1'b1;
        end else begin
          take_next = 1'b1;
        end
      end
      default: begin
        take_next = 1'b1;
      end
    endcase

    // Loading straight out of the last bit keeps streaming free of dead cycles.
    if (take_next) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        word_d  = fifo_data;
        cnt_d   = '0;
        state_d = ST_SHIFT;
        s_out_d = link_bit(fifo_data, '0);
        busy_d  = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State and registered outputs; reset aborts any word in flight without a SYNC.
  always_ff @(posedge LINK_CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      gap_q   <= '0;
      s_out_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
      s_out_q <= s_out_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
    end
  end

  assign S_OUT      = s_out_q;
  assign SYNC       = sync_q;
  assign BUSY       = busy_q;
  assign DATA_READY = !fifo_full;
  assign FIFO_LEVEL = fifo_level;

endmodule

// File: doc/link_transmitter.md
Name: link_transmitter

Overview:
Serialiser that sits directly upstream of the link receiver and drives its S_IN/SYNC pair. It accepts 16-bit words from the game logic over a valid/ready handshake and buffers them in a small FIFO. Each word is shifted out one bit per LINK_CLK, and SYNC is pulsed on the last bit so the receiver latches the complete word.

Parameters:
FIFO_DEPTH, 4, number of buffered words (power of two, at least 2)
IDLE_GAP, 0, forced idle cycles between consecutive words (0 = back-to-back)

Ports:
LINK_CLK  in  1  link clock; all logic on its rising edge
RESET  in  1  synchronous reset, active-high
DATA_IN  in  16 [0:15]  word to send; bit 0 is sent first
DATA_VALID  in  1  DATA_IN is valid this cycle
DATA_READY  out  1  FIFO can accept a word; a transfer occurs on DATA_VALID && DATA_READY at a rising edge
S_OUT  out  1  serial data to the receiver's S_IN
SYNC  out  1  high exactly during the final bit of each word
BUSY  out  1  high while a word is being shifted or during the idle gap
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Reset (RESET high at an edge):
  - S_OUT=0, SYNC=0, BUSY=0, FIFO_LEVEL=0, DATA_READY=1.
  - FIFO pointers are cleared, the bit counter is 0, state is IDLE.
- Reset mid-word:
  - Shifting is aborted and SYNC is never issued, so the receiver produces no RECV_OK for the partial word.
  - Buffered words are discarded.
- All outputs are registered. DATA_READY = (FIFO_LEVEL != FIFO_DEPTH).
- FIFO behaviour:
  - Push when DATA_VALID && DATA_READY.
  - Pop when the shifter loads a word.
  - A push and a pop in the same cycle leave the level unchanged.
  - When full, DATA_READY is low, so no push occurs even if a pop happens that cycle.
- State machine:
  - IDLE: S_OUT=0, SYNC=0, BUSY=0. If the FIFO is non-empty, pop the head into the shift register, drive S_OUT=word[0], set bit counter=0, go to SHIFT.
  - SHIFT: each edge increments the counter and drives S_OUT=word[counter]. SYNC=1 only while counter==15 (S_OUT=word[15]).
  - Exit from SHIFT after counter==15:
    - if IDLE_GAP>0, go to GAP;
    - else if the FIFO is non-empty, load the next word immediately (no dead cycle, next bit 0 follows bit 15);
    - else go to IDLE.
  - GAP: hold S_OUT=0, SYNC=0, BUSY=1 for IDLE_GAP cycles, then behave as IDLE.
- Latency, FIFO empty and IDLE:
  - word accepted at edge E0;
  - bit 0 appears on S_OUT after E1;
  - bit 15 with SYNC=1 after E16;
  - the receiver presents the word with RECV_OK after E17.
- Throughput:
  - one word per 16 cycles with IDLE_GAP=0;
  - 16+IDLE_GAP cycles otherwise.
  - SYNC period in continuous streaming is exactly 16+IDLE_GAP cycles.
- Bit order matches the receiver, which assembles the oldest bit into DATA_OUT[0]: word[0] first, word[15] last.
- The word being shifted is held in a dedicated register. FIFO contents and pushes during shifting do not affect it.

Decomposition:
- Shared package link_pkg:
  - LINK_WORD_W=16, LINK_CNT_W=4;
  - state enum {IDLE, SHIFT, GAP};
  - the bit-order convention constant used by both the transmitter and the receiver.
- One sub-module: link_tx_fifo, a synchronous FIFO with push/pop/level/full/empty, same clock and reset. The transmitter instantiates it plus the shifter FSM.

Test Plan:
- Reset, then push 0x8001 once -> S_OUT sequence 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 from cycle E1. SYNC high only on the 16th bit. A paired receiver gives DATA_OUT=0x8001 with RECV_OK for one cycle.
- Push 0xA5A5, 0x3C3C, 0xFFFF back-to-back with IDLE_GAP=0 -> three SYNC pulses exactly 16 cycles apart, no idle bits. Receiver outputs the three words in order.
- Hold DATA_VALID high with FIFO_DEPTH=4 while one word shifts -> DATA_READY drops when FIFO_LEVEL=4. Exactly 5 words accepted before stall. The stalled word is accepted the cycle after the next pop.
- Set IDLE_GAP=3 and stream two words -> after the first SYNC, 3 cycles of S_OUT=0/SYNC=0/BUSY=1, then bit 0 of word 2. SYNC period 19.
- Assert RESET at bit 7 of 0x1234 with two words queued -> next cycle S_OUT=0, SYNC=0, FIFO_LEVEL=0, DATA_READY=1. Receiver RECV_OK never asserts for the aborted word.
- Push and pop in the same cycle at FIFO_LEVEL=2 -> level stays 2, and order is preserved in the serial output.
